// File: rtl/dc_video_pkg.sv
// Shared timing constants, pattern encodings and bar colours for the Dreamcast video source.
package dc_video_pkg;

  localparam logic [9:0] V_TOTAL_480     = 10'd525;
  localparam logic [9:0] VSYNC_LEN_480   = 10'd6;
  localparam logic [9:0] V_ACT_START_480 = 10'd36;
  localparam logic [9:0] V_ACT_LEN_480   = 10'd480;

  localparam logic [9:0] V_TOTAL_240     = 10'd263;
  localparam logic [9:0] VSYNC_LEN_240   = 10'd3;
  localparam logic [9:0] V_ACT_START_240 = 10'd18;
  localparam logic [9:0] V_ACT_LEN_240   = 10'd240;

  localparam int unsigned BAR_WIDTH = 80;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  typedef enum logic {
    MODE_480P = 1'b0,
    MODE_240P = 1'b1
  } mode_e;

  typedef struct packed {
    logic [9:0] total;
    logic [9:0] sync_len;
    logic [9:0] act_start;
    logic [9:0] act_len;
  } vtiming_t;

  function automatic vtiming_t vtiming(input mode_e mode);
    vtiming_t t;
    if (mode == MODE_240P) begin
      t = '{total: V_TOTAL_240, sync_len: VSYNC_LEN_240,
            act_start: V_ACT_START_240, act_len: V_ACT_LEN_240};
    end else begin
      t = '{total: V_TOTAL_480, sync_len: VSYNC_LEN_480,
            act_start: V_ACT_START_480, act_len: V_ACT_LEN_480};
    end
    return t;
  endfunction

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dc_pattern_rgb.sv
// Test-pattern colour for one active pixel, from its coordinates within the active window.
module dc_pattern_rgb
  import dc_video_pkg::*;
(
  input  logic [9:0]  ax,
  input  logic [9:0]  ay,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] rgb
);

  logic [9:0] bar_idx;
  logic       unused_ay;

  assign unused_ay = ^{ay[9:4], ay[2:0]};
  assign bar_idx   = ax / 10'(BAR_WIDTH);

  always_comb begin
    rgb = '0;
    case (pattern_e'(pattern_sel))
      PAT_BARS:    rgb = (bar_idx < 10'd8) ? bar_rgb(bar_idx[2:0]) : '0;
      PAT_RAMP:    rgb = {3{ax[7:0]}};
      PAT_CHECKER: rgb = (ax[3] ^ ay[3]) ? '1 : '0;
      PAT_SOLID:   rgb = solid_rgb;
      default:     rgb = '0;
    endcase
  end

endmodule

// File: rtl/dc_video_gen.sv
// Dreamcast-format 480p/240p test-pattern source driving the 12-bit half-pixel bus.
module dc_video_gen
  import dc_video_pkg::*;
#(
  parameter int unsigned H_TOTAL     = 858,
  parameter int unsigned HSYNC_LEN   = 62,
  parameter int unsigned H_ACT_START = 122,
  parameter int unsigned H_ACT_LEN   = 640
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_doubler,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        _hsync,
  output logic        _vsync,
  output logic [11:0] data,
  output logic        frame_start
);

  // x shares the 10-bit width of ax, so H_TOTAL is limited to 1024.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_END   = 10'(HSYNC_LEN);
  localparam logic [9:0] HA_BEGIN = 10'(H_ACT_START);
  localparam logic [9:0] HA_END   = 10'(H_ACT_START + H_ACT_LEN);

  mode_e       mode_q;
  pattern_e    pat_q;
  logic [23:0] solid_q;
  logic [1:0]  phase_q, phase_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        fs_q, fs_d;
  logic [11:0] data_q, data_d;

  vtiming_t    vt;
  logic [1:0]  phase_last;
  logic        at_origin;
  logic        active;
  logic        second_half;
  logic [9:0]  ax, ay;
  logic [23:0] solid_eff, rgb;

  assign vt         = vtiming(mode_q);
  assign phase_last = (mode_q == MODE_240P) ? 2'd3 : 2'd1;
  assign at_origin  = (phase_q == 2'd0) && (x_q == '0) && (y_q == '0);
  assign ax         = x_q - HA_BEGIN;
  assign ay         = y_q - vt.act_start;
  // Phase 0 takes solid_rgb straight from the pin so the held copy is not a cycle late.
  assign solid_eff  = (phase_q == 2'd0) ? solid_rgb : solid_q;

  dc_pattern_rgb u_pattern (
    .ax          (ax),
    .ay          (ay),
    .pattern_sel (pat_q),
    .solid_rgb   (solid_eff),
    .rgb         (rgb)
  );

  always_comb begin
    phase_d = phase_q + 2'd1;
    x_d     = x_q;
    y_d     = y_q;
    if (phase_q == phase_last) begin
      phase_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == vt.total - 10'd1) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Mode is stale during the origin state itself, which is harmless: phase 0 never wraps and line 0 is blank.
  always_comb begin
    active      = (x_q >= HA_BEGIN) && (x_q < HA_END) &&
                  (y_q >= vt.act_start) && (y_q < vt.act_start + vt.act_len);
    second_half = (mode_q == MODE_240P) ? phase_q[1] : phase_q[0];
    hsync_d     = (x_q >= HS_END);
    vsync_d     = (y_q >= vt.sync_len);
    fs_d        = at_origin;
    data_d      = '0;
    if (active) begin
      data_d = second_half ? rgb[11:0] : rgb[23:12];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= mode_e'(line_doubler);
      pat_q   <= pattern_e'(pattern_sel);
      solid_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      data_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (at_origin) begin
        mode_q <= mode_e'(line_doubler);
        pat_q  <= pattern_e'(pattern_sel);
      end
      if (phase_q == 2'd0) begin
        solid_q <= solid_rgb;
      end
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
    end
  end

  assign _hsync      = hsync_q;
  assign _vsync      = vsync_q;
  assign data        = data_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_dc_video_gen.sv
// Randomised bench for dc_video_gen against a cycle-index reference model, using short lines to bound run time.
module tb_dc_video_gen;

  localparam int unsigned HT   = 24;
  localparam int unsigned HSL  = 4;
  localparam int unsigned HA0  = 6;
  localparam int unsigned HAL  = 16;
  localparam int unsigned F480 = 2 * HT * 525;
  localparam int unsigned F240 = 4 * HT * 263;

  logic        clock = 1'b0;
  logic        reset;
  logic        line_doubler;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        _hsync, _vsync, frame_start;
  logic [11:0] data;

  logic [9:0]  p_ax, p_ay;
  logic [1:0]  p_sel;
  logic [23:0] p_solid, p_rgb;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int unsigned m_t = 0, m_pat = 0, m_period = 0;
  bit          m_240 = 1'b0;
  logic [23:0] m_solid = '0;
  logic        e_hs, e_vs, e_fs;
  logic [11:0] e_data;
  bit          dir_on = 1'b0;
  string       dir_tag = "";
  logic [11:0] dir_exp;

  int unsigned cyc = 0, last_fs = 0, prev_period = 0;
  bit          have_prev = 1'b0;

  always #5 clock = ~clock;

  dc_video_gen #(
    .H_TOTAL     (HT),
    .HSYNC_LEN   (HSL),
    .H_ACT_START (HA0),
    .H_ACT_LEN   (HAL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .line_doubler (line_doubler),
    .pattern_sel  (pattern_sel),
    .solid_rgb    (solid_rgb),
    ._hsync       (_hsync),
    ._vsync       (_vsync),
    .data         (data),
    .frame_start  (frame_start)
  );

  dc_pattern_rgb u_pat (
    .ax          (p_ax),
    .ay          (p_ay),
    .pattern_sel (p_sel),
    .solid_rgb   (p_solid),
    .rgb         (p_rgb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int unsigned ax, input int unsigned ay,
                                          input int unsigned pat, input logic [23:0] solid);
    int unsigned bar;
    logic [7:0]  lvl;
    case (pat)
      0: begin
        bar = ax / 80;
        return {((bar % 4) < 2) ? 8'hFF : 8'h00, (bar < 4) ? 8'hFF : 8'h00,
                ((bar % 2) == 0) ? 8'hFF : 8'h00};
      end
      1: begin
        lvl = 8'(ax % 256);
        return {lvl, lvl, lvl};
      end
      2: return (((ax / 8) % 2) != ((ay / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  // Frame position is derived from the number of clocks since the frame began.
  task automatic model_edge();
    int unsigned cpp, vt, vs_len, vas, val, ph, x, y;
    logic [23:0] rgb;
    dir_on = 1'b0;
    if (reset) begin
      e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_data = '0;
      m_t = 0;
      have_prev = 1'b0;
      return;
    end
    if (m_t == 0) begin
      m_240 = line_doubler;
      m_pat = pattern_sel;
    end
    cpp    = m_240 ? 4 : 2;
    vt     = m_240 ? 263 : 525;
    vs_len = m_240 ? 3 : 6;
    vas    = m_240 ? 18 : 36;
    val    = m_240 ? 240 : 480;
    ph = m_t % cpp;
    x  = (m_t / cpp) % HT;
    y  = m_t / (cpp * HT);
    if (ph == 0) m_solid = solid_rgb;
    if (m_t == 0) m_period = cpp * HT * vt;
    e_hs   = (x >= HSL);
    e_vs   = (y >= vs_len);
    e_fs   = (m_t == 0);
    e_data = '0;
    if (x >= HA0 && x < HA0 + HAL && y >= vas && y < vas + val) begin
      rgb    = ref_rgb(x - HA0, y - vas, m_pat, m_solid);
      e_data = (ph < cpp / 2) ? rgb[23:12] : rgb[11:0];
      if (m_pat == 1 && !m_240 && y == vas && x == HA0) begin
        dir_on = 1'b1; dir_tag = "ramp_first"; dir_exp = 12'h000;
      end else if (m_pat == 1 && !m_240 && y == vas && x == HA0 + 5) begin
        dir_on = 1'b1; dir_tag = "ramp_ax5"; dir_exp = (ph == 0) ? 12'h050 : 12'h505;
      end else if (m_pat == 3 && m_240 && m_solid == 24'h123456) begin
        dir_on = 1'b1; dir_tag = "solid_240p"; dir_exp = (ph < 2) ? 12'h123 : 12'h456;
      end
    end
    m_t = (m_t + 1) % (cpp * HT * vt);
  endtask

  task automatic run(input int unsigned n, input bit rnd_solid);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      cyc++;
      chk("hsync", 32'(_hsync), 32'(e_hs));
      chk("vsync", 32'(_vsync), 32'(e_vs));
      chk("data", 32'(data), 32'(e_data));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      if (dir_on) chk(dir_tag, 32'(data), 32'(dir_exp));
      if (frame_start === 1'b1) begin
        if (have_prev) chk("frame_period", cyc - last_fs, prev_period);
        have_prev   = 1'b1;
        last_fs     = cyc;
        prev_period = m_period;
      end
      if (rnd_solid) solid_rgb = $urandom;
    end
  endtask

  initial begin
    int unsigned mid;
    reset        = 1'b1;
    line_doubler = 1'b0;
    pattern_sel  = 2'd1;
    solid_rgb    = $urandom;

    for (int i = 0; i < 8; i++) begin
      p_sel   = 2'd0;
      p_ax    = 10'(80 * i + 40);
      p_ay    = 10'($urandom_range(0, 479));
      p_solid = $urandom;
      #1;
      chk("bar_colour", 32'(p_rgb), 32'(ref_rgb(p_ax, p_ay, 0, p_solid)));
    end
    for (int i = 0; i < 400; i++) begin
      p_sel   = 2'($urandom_range(0, 3));
      p_ax    = 10'($urandom_range(0, 639));
      p_ay    = 10'($urandom_range(0, 479));
      p_solid = $urandom;
      #1;
      chk("pattern_rgb", 32'(p_rgb), 32'(ref_rgb(p_ax, p_ay, p_sel, p_solid)));
    end

    // Frame 1: 480p ramp; switch to 240p solid mid-frame.
    run(4, 1'b0);
    reset = 1'b0;
    mid = $urandom_range(5000, 20000);
    run(mid, 1'b0);
    pattern_sel  = 2'd3;
    line_doubler = 1'b1;
    solid_rgb    = 24'h123456;
    run(F480 - mid + 100, 1'b0);

    // Frame 2: 240p solid, then random solid with a switch to 480p checker.
    mid = $urandom_range(8000, 14000);
    run(mid, 1'b0);
    pattern_sel  = 2'd2;
    line_doubler = 1'b0;
    run(F240 - mid, 1'b1);

    // Frame 3: 480p checker, aborted by reset around line 200.
    run(200 * 2 * HT + 20 - 100, 1'b0);
    pattern_sel = 2'd0;
    reset = 1'b1;
    run(3, 1'b0);
    reset = 1'b0;

    // Frame 4: full 480p bars frame plus the next frame start.
    run(F480 + 20, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dc_video_gen.md
DC_VIDEO_GEN -- requirements
Module: dc_video_gen

Interface
REQ-001 Parameter H_TOTAL, default 858, pixels per line.
REQ-002 Parameter HSYNC_LEN, default 62, hsync width in pixels.
REQ-003 Parameter H_ACT_START, default 122, first active pixel.
REQ-004 Parameter H_ACT_LEN, default 640, active pixels per line.
REQ-005 Ports, one per line:
- clock  in  1  54 MHz; sole clock; one clock, no other clock domain.
- reset  in  1  synchronous, active-high.
- line_doubler  in  1  1 = 240p mode, 0 = 480p mode.
- pattern_sel  in  2  0 = colour bars, 1 = grey ramp, 2 = checkerboard, 3 = solid.
- solid_rgb  in  24  {R,G,B} colour used by pattern 3.
- _hsync  out  1  active-low horizontal sync.
- _vsync  out  1  active-low vertical sync.
- data  out  12  half-pixel bus, same format the data input block decodes.
- frame_start  out  1  one-cycle pulse with the first cycle of each frame.

Function
REQ-006 The block SHALL generate Dreamcast-format video: each pixel occupies CPP clocks, with CPP = 2 in 480p and 4 in 240p.
REQ-007 Half-pixel 0 SHALL be {R[7:0],G[7:4]} and half-pixel 1 SHALL be {G[3:0],B[7:0]}; in 240p each half is held 2 clocks (phase order 0,0,1,1).
REQ-008 Counters: phase (0..CPP-1), x (0..H_TOTAL-1) and y (0..V_TOTAL-1); x advances when phase wraps, y advances when x wraps, and y wraps to 0.
REQ-009 V_TOTAL SHALL be 525 in 480p and 263 in 240p; VSYNC_LEN 6 / 3; V_ACT_START 36 / 18; V_ACT_LEN 480 / 240.
REQ-010 _hsync SHALL be 0 while x < HSYNC_LEN, else 1; _vsync SHALL be 0 while y < VSYNC_LEN, else 1.
REQ-011 Active when H_ACT_START <= x < H_ACT_START+H_ACT_LEN and V_ACT_START <= y < V_ACT_START+V_ACT_LEN; data SHALL be 12'h000 outside the active region.
REQ-012 ax = x-H_ACT_START and ay = y-V_ACT_START are 10-bit; patterns:
- bars: 8 bars of 80 px, index ax/80 -> white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00).
- ramp: R=G=B=ax[7:0].
- checker: white if ax[3]^ay[3], else black.
- solid: solid_rgb.
REQ-013 All outputs SHALL be registered, with exactly 1 clock latency from counter state to output pins; sync and data SHALL stay aligned.
REQ-014 line_doubler and pattern_sel SHALL be sampled only at the frame boundary (phase=0, x=0, y=0); mid-frame changes SHALL take effect on the next frame.
REQ-015 solid_rgb SHALL be sampled at each pixel's phase 0 and held for the pixel.
REQ-016 frame_start SHALL assert for exactly one clock, coincident with the output cycle of phase=0, x=0, y=0.
REQ-017 The frame period SHALL be exactly CPP*H_TOTAL*V_TOTAL clocks: 900900 in 480p and 902616 in 240p.

Reset
REQ-018 While reset=1: phase, x and y = 0; _hsync = 1; _vsync = 1; data = 0; frame_start = 0; mode and pattern registers load their current inputs.
REQ-019 Reset asserted mid-frame SHALL abort the frame; the first clock after reset deasserts SHALL begin a new frame at phase=0, x=0, y=0, and frame_start SHALL pulse on the following clock.

Structure
REQ-020 A shared package dc_video_pkg SHALL hold the timing constants (totals, sync lengths, active starts and lengths for both modes), the pattern_sel encodings and the bar colour table.
REQ-021 Pattern colour computation SHALL be one sub-module, dc_pattern_rgb (inputs ax, ay, pattern_sel, solid_rgb; output 24-bit RGB); counters, sync generation and output registers stay in dc_video_gen.

Verification
REQ-022 480p, pattern 0 after reset -> _hsync low for 124 clocks every 1716; _vsync low 6 lines; frame_start period 900900 clocks.
REQ-023 480p, pattern 1, first active pixel of line 36 -> data 12'h000, then 12'h000; pixel ax=5 -> 12'h050, 12'h505.
REQ-024 240p, pattern 3, solid_rgb=24'h123456 -> each active pixel outputs 12'h123 for 2 clocks, then 12'h456 for 2 clocks; V_TOTAL=263, frame period 902616.
REQ-025 pattern_sel changed 0->2 mid-frame -> bars continue to the frame end; checkerboard starts with the frame_start pulse; line_doubler toggled mid-frame -> period changes only from the next frame.
REQ-026 Reset pulsed at y=200, x=400 -> outputs take reset values; after release, _hsync falls and frame_start pulses 2 clocks after reset deasserts; timing checker passes a full frame.
REQ-027 Loopback: dc_video_gen output into the existing data input block in both modes -> decoded RGB and counters match dc_pattern_rgb for every active pixel of 2 frames.
